pll_reset_ce_gen: RTL and testbench

- Sits directly downstream of the system PLL (42 MHz / 7 MHz outputs plus an asynchronous `locked` flag).
- Runs on the 42 MHz system clock.
- Qualifies the PLL lock, sequences the core reset, and produces single-cycle clock enables for the pixel pipeline and the Z80 CPU.
- The rest of the core uses only `clk` plus these enables; no logic runs off the derived PLL clocks directly.

---
 rtl/pll_reset_pkg.sv | 23 ++
 rtl/pll_reset_ce_gen_ce_divider.sv | 33 +++
 rtl/pll_reset_ce_gen.sv | 108 ++++++++++
 tb/tb_pll_reset_ce_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL lock qualifier, reset sequencer and clock-enable generator.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int HOLD_CYCLES_DEF = 64;
  localparam int DIV_PIX_DEF     = 6;
  localparam int DIV_CPU_DEF     = 10;

  // Width of the shared lock/hold counter: must hold max(a,b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_ce_gen_ce_divider.sv
// Free-running divider producing a registered one-cycle enable every DIV cycles while run is high.
module ce_divider
  import pll_reset_pkg::*;
#(
  parameter int DIV = DIV_PIX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic ce
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_r;

  // Divider counter and enable pulse; restart re-phases so the first pulse lands DIV cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
      ce    <= 1'b0;
    end else if (restart || !run) begin
      cnt_r <= '0;
      ce    <= 1'b0;
    end else begin
      ce    <= (cnt_r == LAST);
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Qualifies PLL lock, sequences the core reset and generates pixel/CPU clock enables on clk.
module pll_reset_ce_gen
  import pll_reset_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int DIV_PIX     = DIV_PIX_DEF,
  parameter int DIV_CPU     = DIV_CPU_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic ext_reset,
  output logic core_reset,
  output logic ready,
  output logic ce_pix,
  output logic ce_cpu
);

  localparam int CW = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic          sync1_r;
  logic          lk_s;
  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_step_s;
  logic [CW-1:0] cnt_next_s;
  logic          run_s;
  logic          restart_s;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      lk_s    <= sync1_r;
    end
  end

  // Next-state and shared counter logic; lock loss outranks ext_reset in every state.
  always_comb begin
    next_state_s = state_r;
    cnt_step_s   = cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_s) next_state_s = STABLE;
        else      next_state_s = WAIT_LOCK;
      end
      STABLE: begin
        if (!lk_s)                   next_state_s = WAIT_LOCK;
        else if (cnt_r == LOCK_LAST) next_state_s = HOLD;
        else                         cnt_step_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      HOLD: begin
        if (!lk_s)                   next_state_s = WAIT_LOCK;
        else if (ext_reset)          cnt_step_s   = '0;
        else if (cnt_r == HOLD_LAST) next_state_s = RUN;
        else                         cnt_step_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      RUN: begin
        if (!lk_s)          next_state_s = WAIT_LOCK;
        else if (ext_reset) next_state_s = HOLD;
        else                next_state_s = RUN;
      end
      default: next_state_s = WAIT_LOCK;
    endcase
    cnt_next_s = (next_state_s != state_r) ? '0 : cnt_step_s;
    run_s      = (next_state_s == HOLD) || (next_state_s == RUN);
    restart_s  = (next_state_s == HOLD) && (state_r != HOLD);
  end

  // State, counter and registered reset outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= WAIT_LOCK;
      cnt_r      <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= cnt_next_s;
      core_reset <= (next_state_s != RUN);
      ready      <= (next_state_s == RUN);
    end
  end

  ce_divider #(.DIV(DIV_PIX)) u_div_pix (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run_s),
    .restart (restart_s),
    .ce      (ce_pix)
  );

  ce_divider #(.DIV(DIV_CPU)) u_div_cpu (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run_s),
    .restart (restart_s),
    .ce      (ce_cpu)
  );

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed plus randomized bench for pll_reset_ce_gen, checked against a cycle-level behavioural model.
module tb_pll_reset_ce_gen;

  localparam int LOCK = 8;
  localparam int HOLDC = 4;
  localparam int DP = 6;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n, pll_locked, ext_reset;
  logic core_reset, ready, ce_pix, ce_cpu;

  always #5 clk = ~clk;

  pll_reset_ce_gen #(
    .LOCK_CYCLES(LOCK), .HOLD_CYCLES(HOLDC), .DIV_PIX(DP), .DIV_CPU(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .ext_reset(ext_reset),
    .core_reset(core_reset), .ready(ready), .ce_pix(ce_pix), .ce_cpu(ce_cpu)
  );

  // Model: qual = consecutive edges with synchronised lock high; hold_cnt = quiet cycles in hold;
  // div_age = cycles since dividers were last (re)started.
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  m_s1, m_lk, m_ready, e_pix, e_cpu;
  int  qual, hold_cnt, div_age;

  task automatic model_edge();
    if (!rst_n) begin
      m_s1 = 0; m_lk = 0; qual = 0; hold_cnt = 0; div_age = 0;
      m_ready = 0; e_pix = 0; e_cpu = 0;
    end else begin
      if (!m_lk) begin
        qual = 0; m_ready = 0; e_pix = 0; e_cpu = 0;
      end else begin
        if (qual < LOCK + 2) qual++;
        if (qual == LOCK + 1) begin
          hold_cnt = 0; div_age = 0; e_pix = 0; e_cpu = 0;
        end else if (qual > LOCK + 1) begin
          if (m_ready && ext_reset) begin
            m_ready = 0; hold_cnt = 0; div_age = 0; e_pix = 0; e_cpu = 0;
          end else begin
            div_age++;
            e_pix = (div_age % DP == 0);
            e_cpu = (div_age % DC == 0);
            if (!m_ready) begin
              if (ext_reset) hold_cnt = 0;
              else if (hold_cnt == HOLDC - 1) m_ready = 1;
              else hold_cnt++;
            end
          end
        end
      end
      m_lk = m_s1;
      m_s1 = pll_locked;
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("core_reset", core_reset, !m_ready);
    chk("ready", ready, m_ready);
    chk("ce_pix", ce_pix, e_pix);
    chk("ce_cpu", ce_cpu, e_cpu);
  endtask

  initial begin
    int rel, pix1, npix, ncpu, ext_left;
    logic prev_pix, prev_cpu;

    // Power-up reset
    rst_n = 1'b0; pll_locked = 1'b0; ext_reset = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: lock rises, release after edge 14, first ce_pix after edge 16
    pll_locked = 1'b1;
    rel = -1; pix1 = -1;
    for (int e = 0; e < 40; e++) begin
      step();
      if (ready && rel < 0) rel = e;
      if (ce_pix && pix1 < 0) pix1 = e;
    end
    chk_int("startup_release_edge", rel, 2 + LOCK + HOLDC);
    chk_int("first_ce_pix_edge", pix1, 2 + LOCK + DP);

    // 2: lock bounce restarts qualification
    pll_locked = 1'b0;
    repeat (4) step();
    pll_locked = 1'b1;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    rel = -1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (ready && rel < 0) rel = e;
    end
    chk_int("bounce_release_edge", rel, 2 + LOCK + HOLDC);

    // 3: lock loss in RUN, then full requalification
    pll_locked = 1'b0;
    repeat (20) step();
    chk_int("lockloss_ready", int'(ready), 0);
    pll_locked = 1'b1;
    repeat (20) step();

    // 4: ext_reset held 10 cycles in RUN
    ext_reset = 1'b1;
    repeat (10) step();
    ext_reset = 1'b0;
    rel = -1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (ready && rel < 0) rel = e;
    end
    chk_int("ext_release_edge", rel, HOLDC - 1);

    // 5: rst_n mid-RUN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (25) step();

    // 6: periodicity over 600 RUN cycles
    npix = 0; ncpu = 0; prev_pix = 1'b0; prev_cpu = 1'b0;
    for (int e = 0; e < 600; e++) begin
      step();
      if (ce_pix) npix++;
      if (ce_cpu) ncpu++;
      if (ce_pix && prev_pix) chk("pix_width", ce_pix, 1'b0);
      if (ce_cpu && prev_cpu) chk("cpu_width", ce_cpu, 1'b0);
      prev_pix = ce_pix;
      prev_cpu = ce_cpu;
    end
    chk_int("ce_pix_count", npix, 600 / DP);
    chk_int("ce_cpu_count", ncpu, 600 / DC);

    // Randomized lock dropouts, ext_reset bursts and occasional rst_n
    ext_left = 0;
    for (int e = 0; e < 1500; e++) begin
      pll_locked = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 99) < 3) ext_left = $urandom_range(1, 12);
      ext_reset = (ext_left > 0);
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
